// File: rtl/alu_exec_control.sv
// Multi-cycle execute controller for the 16-bit add/sub/compare ALU: decode, two
// operand reads over the shared bus, ALU control, result capture and write-back.
//
// state  | meaning
// IDLE   | waiting for run; ir latched on the accepting edge
// T1     | read rx onto the bus, load A
// T2     | read ry onto the bus, drive ALU controls, load G
// T3     | write G back to rx, pulse done
// ERR    | illegal opcode, pulse done and err
module alu_exec_control (
   input  logic        clock,
   input  logic        resetn,
   input  logic        run,
   input  logic [15:0] ir,
   input  logic [15:0] bus_in,
   input  logic [15:0] alu_result,
   output logic [2:0]  rd_sel,
   output logic [15:0] alu_rx,
   output logic [15:0] alu_ry,
   output logic        soma,
   output logic        add_sub,
   output logic        comparacao,
   output logic        maior_menor,
   output logic        wr_en,
   output logic [2:0]  wr_sel,
   output logic [15:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] a_q, a_d;
   logic [15:0] g_q, g_d;
   logic [2:0]  rd_sel_q, rd_sel_d;
   logic [2:0]  wr_sel_q, wr_sel_d;
   logic        soma_q, soma_d;
   logic        add_sub_q, add_sub_d;
   logic        comparacao_q, comparacao_d;
   logic        maior_menor_q, maior_menor_d;
   logic        wr_en_q, wr_en_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [3:0]  op_d;

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      a_d     = a_q;
      g_d     = g_q;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               ir_d    = ir;
               state_d = (ir[15:14] != 2'b00) ? S_ERR : S_T1;
            end
         end
         S_T1: begin
            a_d     = bus_in;
            state_d = S_T2;
         end
         S_T2: begin
            g_d     = alu_result;
            state_d = S_T3;
         end
         S_T3:    state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they come straight off flops
      // and line up with the state they belong to.
      op_d          = ir_d[15:12];
      rd_sel_d      = 3'd0;
      wr_sel_d      = 3'd0;
      soma_d        = 1'b0;
      add_sub_d     = 1'b0;
      comparacao_d  = 1'b0;
      maior_menor_d = 1'b0;
      wr_en_d       = 1'b0;
      busy_d        = (state_d != S_IDLE);
      done_d        = (state_d == S_T3) || (state_d == S_ERR);
      err_d         = (state_d == S_ERR);
      case (state_d)
         S_T1: rd_sel_d = ir_d[11:9];
         S_T2: begin
            rd_sel_d      = ir_d[8:6];
            soma_d        = (op_d == 4'd0) || (op_d == 4'd1);
            add_sub_d     = (op_d == 4'd1);
            comparacao_d  = (op_d == 4'd2);
            maior_menor_d = (op_d == 4'd3);
         end
         S_T3: begin
            wr_en_d  = 1'b1;
            wr_sel_d = ir_d[11:9];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         ir_q          <= 16'd0;
         a_q           <= 16'd0;
         g_q           <= 16'd0;
         rd_sel_q      <= 3'd0;
         wr_sel_q      <= 3'd0;
         soma_q        <= 1'b0;
         add_sub_q     <= 1'b0;
         comparacao_q  <= 1'b0;
         maior_menor_q <= 1'b0;
         wr_en_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         a_q           <= a_d;
         g_q           <= g_d;
         rd_sel_q      <= rd_sel_d;
         wr_sel_q      <= wr_sel_d;
         soma_q        <= soma_d;
         add_sub_q     <= add_sub_d;
         comparacao_q  <= comparacao_d;
         maior_menor_q <= maior_menor_d;
         wr_en_q       <= wr_en_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   assign rd_sel      = rd_sel_q;
   assign alu_rx      = a_q;
   assign alu_ry      = bus_in;
   assign soma        = soma_q;
   assign add_sub     = add_sub_q;
   assign comparacao  = comparacao_q;
   assign maior_menor = maior_menor_q;
   assign wr_en       = wr_en_q;
   assign wr_sel      = wr_sel_q;
   assign wr_data     = g_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: doc/alu_exec_control.md
# alu_exec_control

Multi-cycle execute controller sitting directly upstream of the 16-bit add/subtract/compare ALU stage. On a `run` request it decodes an instruction word, fetches two operands from the external register file over a shared 16-bit bus, drives the ALU's one-hot control lines, captures the ALU result, and writes it back to the destination register. It owns the operand latch A and the result latch G, and it produces every control signal the ALU consumes.

## Interface
- No parameters; data width fixed at 16, register index fixed at 3 bits.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `run`  in  1  start request, sampled only in IDLE.
- `ir`  in  16  instruction: opcode `ir[15:12]`, rx `ir[11:9]` (first operand and destination), ry `ir[8:6]` (second operand); `ir[5:0]` ignored.
- `bus_in`  in  16  register-file read data for the register selected by `rd_sel`, same cycle.
- `alu_result`  in  16  ALU output, combinational from `alu_rx`, `alu_ry` and the control lines.
- `rd_sel`  out  3  register-file read select.
- `alu_rx`  out  16  ALU first operand; always equal to A.
- `alu_ry`  out  16  ALU second operand; always equal to `bus_in`.
- `soma`, `add_sub`, `comparacao`, `maior_menor`  out  1 each  ALU controls.
- `wr_en`  out  1  register-file write strobe.
- `wr_sel`  out  3  write destination.
- `wr_data`  out  16  write data; always equal to G.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle illegal-opcode pulse, coincident with `done`.

## Operation
- Opcodes: 0000 ADD (`soma`=1, `add_sub`=0); 0001 SUB (`soma`=1, `add_sub`=1); 0010 SEQ (`comparacao`=1); 0011 SGT (`maior_menor`=1, unsigned rx > ry). Opcodes 0100–1111 are illegal.
- Internal registers: IR (16), A (16), G (16), state.
- States and transitions:
  - IDLE: if `run`=1, latch `ir` into IR. Next state is ERR if the opcode is illegal, otherwise T1.
  - T1: `rd_sel`=IR.rx. Edge loads A←`bus_in`. Next state T2.
  - T2: `rd_sel`=IR.ry. Exactly one ALU control line group is asserted, per opcode. Edge loads G←`alu_result`. Next state T3.
  - T3: `wr_en`=1, `wr_sel`=IR.rx, `done`=1. Next state IDLE.
  - ERR: `done`=1, `err`=1, `wr_en`=0. Next state IDLE.
- Outside T2, all ALU control lines are 0. Outside T3, `wr_en`=0. In IDLE and ERR, `rd_sel`=0.
- `wr_sel` is 0 except in T3.
- `run` is ignored while `busy`=1. `ir` is only sampled at the IDLE→T1/ERR edge, so later changes to `ir` have no effect.
- rx==ry is legal. A holds the value read in T1 and the bus rereads the same register in T2, so ADD doubles the value and SEQ yields 1.
- Arithmetic is modulo 2^16, done by the ALU. G captures the full 16 bits. Compare results are 0x0001 or 0x0000.

## Timing
- Reset (`resetn`=0, asynchronous): state=IDLE; IR=A=G=0; `rd_sel`=`wr_sel`=0; `wr_en`=`busy`=`done`=`err`=0; all ALU controls 0. `alu_rx`=0 and `wr_data`=0 follow from A and G.
- Reset mid-operation aborts immediately. No write occurs, and no `done` is produced for the aborted instruction.
- Legal instruction: `run` sampled at edge 0. T1 occupies cycle 1, T2 cycle 2, T3 cycle 3. `done` and `wr_en` are high in cycle 3, and the register file commits at edge 3→4.
- Illegal instruction: `done` and `err` are high in cycle 1, and the block is back in IDLE at cycle 2.
- The earliest next `run` sample is the first IDLE cycle (cycle 4 for a legal instruction), giving a minimum issue interval of 4 cycles.
- All outputs are registered-state decodes: Moore outputs, no combinational path from `run` to any output.

## Test plan
- ADD, R1=5, R2=7: `ir`=0x0280 (op 0, rx=1, ry=2). Cycle 3: `wr_en`=1, `wr_sel`=1, `wr_data`=12, `done`=1. `soma`=1 only in cycle 2.
- SUB, R3=3, R4=5: result 0xFFFE written to R3. `add_sub`=1 only in cycle 2.
- SEQ, R1=R2=0x1234 → `wr_data`=0x0001. SGT, R1=2, R2=9 → `wr_data`=0x0000. SGT, R1=0x8000, R2=1 → `wr_data`=0x0001 (unsigned compare).
- Illegal opcode 0111: `done`=`err`=1 in cycle 1. `wr_en` never asserts. A and G unchanged.
- `resetn` pulsed low during T2: all outputs go to 0 asynchronously, and no `wr_en` or `done` occurs afterwards. A new `run` after release completes normally.
- `run` held high continuously and `ir` changed during T2: the second instruction starts only from IDLE (first `done` in cycle 3, second `done` in cycle 7), and the first instruction's write uses the original rx.
